// File: rtl/weighted_sum_mac.sv
// Time-multiplexed weighted-sum unit: LANES multipliers per beat, bias-seeded exact-width accumulator.
// Optional ReLU clamp on signed results when WEIGHTED_SUM_RELU_EN is defined.
module weighted_sum_mac #(
    parameter  int unsigned NUM_INPUTS = 4,
    parameter  int unsigned BIT_LENGTH = 4,
    parameter  int unsigned LANES      = 2,
    localparam int unsigned ACC_W      = 2 * BIT_LENGTH + $clog2(NUM_INPUTS) + 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  signed_mode,
    input  logic [NUM_INPUTS-1:0][BIT_LENGTH-1:0] weights,
    input  logic [NUM_INPUTS-1:0][BIT_LENGTH-1:0] inputs,
    input  logic [BIT_LENGTH-1:0]                 bias,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [ACC_W-1:0]                      out_sum
);

    localparam int unsigned BEATS  = (NUM_INPUTS + LANES - 1) / LANES;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PROD_W = 2 * BIT_LENGTH;
    localparam int unsigned EXT_W  = ACC_W - PROD_W;
    localparam int unsigned BEXT_W = ACC_W - BIT_LENGTH;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                                          state_q;
    logic [CNT_W-1:0]                                beat_q;
    logic [ACC_W-1:0]                                acc_q;
    logic                                            signed_q;
    logic [BEATS-1:0][LANES-1:0][BIT_LENGTH-1:0]     w_q, x_q;
    logic [BEATS-1:0][LANES-1:0][BIT_LENGTH-1:0]     w_pad, x_pad;
    logic [ACC_W-1:0]                                bias_ext;
    logic [ACC_W-1:0]                                partial [LANES+1];

    // Regroup operands into beat-major order; slots past NUM_INPUTS are zero so they add nothing.
    for (genvar b = 0; b < int'(BEATS); b++) begin : g_beat
        for (genvar l = 0; l < int'(LANES); l++) begin : g_slot
            if (b * LANES + l < NUM_INPUTS) begin : g_real
                assign w_pad[b][l] = weights[b*LANES+l];
                assign x_pad[b][l] = inputs[b*LANES+l];
            end else begin : g_zero
                assign w_pad[b][l] = '0;
                assign x_pad[b][l] = '0;
            end
        end
    end

    assign bias_ext   = {{BEXT_W{signed_mode & bias[BIT_LENGTH-1]}}, bias};
    assign partial[0] = acc_q;

    // One multiplier per lane; operands extended to product width by the latched mode.
    for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
        logic [BIT_LENGTH-1:0] w_sel, x_sel;
        logic [PROD_W-1:0]     a_ext, b_ext, prod;
        assign w_sel = w_q[beat_q][l];
        assign x_sel = x_q[beat_q][l];
        assign a_ext = {{BIT_LENGTH{signed_q & w_sel[BIT_LENGTH-1]}}, w_sel};
        assign b_ext = {{BIT_LENGTH{signed_q & x_sel[BIT_LENGTH-1]}}, x_sel};
        assign prod  = a_ext * b_ext;
        assign partial[l+1] = partial[l] + {{EXT_W{signed_q & prod[PROD_W-1]}}, prod};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            acc_q    <= '0;
            signed_q <= 1'b0;
            w_q      <= '0;
            x_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        w_q      <= w_pad;
                        x_q      <= x_pad;
                        signed_q <= signed_mode;
                        acc_q    <= bias_ext;
                        beat_q   <= '0;
                        state_q  <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_q <= partial[LANES];
                    if (beat_q == CNT_W'(BEATS - 1)) begin
                        state_q <= DONE;
                    end else begin
                        beat_q <= beat_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

`ifdef WEIGHTED_SUM_RELU_EN
    assign out_sum = (signed_q && acc_q[ACC_W-1]) ? '0 : acc_q;
`else
    assign out_sum = acc_q;
`endif

endmodule

// File: tb/tb_weighted_sum_mac.sv
// Directed bench for weighted_sum_mac: integer reference model checked every cycle plus literal expectations.
module tb_weighted_sum_mac;

    localparam int N = 4, BW = 4, L = 2, ACC_W = 11, BEATS = 2;
    localparam int N5 = 5, ACC5_W = 12;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_ready, signed_mode, out_valid, out_ready;
    logic [N-1:0][BW-1:0] weights, inputs;
    logic [BW-1:0] bias;
    logic [ACC_W-1:0] out_sum;

    logic in_valid5, in_ready5, out_valid5;
    logic [N5-1:0][BW-1:0] w5, x5;
    logic [ACC5_W-1:0] out_sum5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    weighted_sum_mac #(.NUM_INPUTS(N), .BIT_LENGTH(BW), .LANES(L)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .signed_mode(signed_mode), .weights(weights), .inputs(inputs), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
    );

    weighted_sum_mac #(.NUM_INPUTS(N5), .BIT_LENGTH(BW), .LANES(L)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
        .signed_mode(signed_mode), .weights(w5), .inputs(x5), .bias(bias),
        .out_valid(out_valid5), .out_ready(out_ready), .out_sum(out_sum5)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Plain integer weighted sum, optional ReLU, for up to 8 elements.
    function automatic int ref_sum(input logic [7:0][3:0] w, input logic [7:0][3:0] x,
                                   input logic [3:0] b, input logic s, input int n);
        int acc;
        acc = s ? int'($signed(b)) : int'(b);
        for (int i = 0; i < n; i++) begin
            if (s) acc += int'($signed(w[i])) * int'($signed(x[i]));
            else   acc += int'(w[i]) * int'(x[i]);
        end
`ifdef WEIGHTED_SUM_RELU_EN
        if (s && acc < 0) acc = 0;
`endif
        return acc;
    endfunction

    function automatic logic [7:0][3:0] pad4(input logic [N-1:0][BW-1:0] v);
        logic [7:0][3:0] r;
        r = '0;
        r[N-1:0] = v;
        return r;
    endfunction

    // Cycle-level reference: idle / busy for BEATS cycles / holding a result.
    typedef enum int {M_IDLE, M_BUSY, M_DONE} mph_t;
    mph_t             m_ph   = M_IDLE;
    int               m_left = 0;
    logic [ACC_W-1:0] m_sum  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph   <= M_IDLE;
            m_left <= 0;
            m_sum  <= '0;
        end else begin
            case (m_ph)
                M_IDLE: if (in_valid) begin
                    m_sum  <= ACC_W'(ref_sum(pad4(weights), pad4(inputs), bias, signed_mode, N));
                    m_left <= BEATS;
                    m_ph   <= M_BUSY;
                end
                M_BUSY: begin
                    if (m_left == 1) m_ph <= M_DONE;
                    m_left <= m_left - 1;
                end
                M_DONE: if (out_ready) m_ph <= M_IDLE;
                default: m_ph <= M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("in_ready", longint'(in_ready), longint'(m_ph == M_IDLE));
            check("out_valid", longint'(out_valid), longint'(m_ph == M_DONE));
            if (m_ph == M_DONE) check("out_sum", longint'(out_sum), longint'(m_sum));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0][BW-1:0] w, input logic [N-1:0][BW-1:0] x,
                        input logic [BW-1:0] b, input logic s);
        weights = w; inputs = x; bias = b; signed_mode = s; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            step();
            cycles++;
        end
        if (cycles >= 40) check("done_timeout", longint'(out_valid), 1);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_ph != M_IDLE && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) check("idle_timeout", longint'(in_ready), 1);
    endtask

    initial begin
        int cyc;
        logic [ACC_W-1:0] held;
        logic [ACC_W-1:0] exp_signed;

        rst_n = 1'b0; in_valid = 1'b0; in_valid5 = 1'b0; out_ready = 1'b0;
        signed_mode = 1'b0; weights = '0; inputs = '0; bias = '0; w5 = '0; x5 = '0;
`ifdef WEIGHTED_SUM_RELU_EN
        exp_signed = '0;
`else
        exp_signed = 11'h7ED;
`endif

        check("pin_model_70", ref_sum({16'h0, 16'h4321}, {16'h0, 16'h8765}, 4'd0, 1'b0, 4), 70);
        check("pin_model_915", ref_sum({16'h0, 16'hFFFF}, {16'h0, 16'hFFFF}, 4'hF, 1'b0, 4), 915);
        check("pin_model_20", ref_sum({12'h0, 20'h21111}, {12'h0, 20'h54321}, 4'd0, 1'b0, 5), 20);

        #12;
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_sum", longint'(out_sum), 0);
        step();
        rst_n = 1'b1;
        step();

        // Unsigned {1,2,3,4}.{5,6,7,8}
        send({4'd4, 4'd3, 4'd2, 4'd1}, {4'd8, 4'd7, 4'd6, 4'd5}, 4'd0, 1'b0);
        check("busy_in_ready", longint'(in_ready), 0);
        wait_valid(cyc);
        check("latency", cyc, BEATS);
        check("sum_70", longint'(out_sum), 70);
        release_out();
        check("idle_after_take", longint'(in_ready), 1);

        // Signed {-1,2,-3,4}.{7,-8,1,1} + 3
        send({4'd4, 4'hD, 4'd2, 4'hF}, {4'd1, 4'd1, 4'h8, 4'd7}, 4'd3, 1'b1);
        wait_valid(cyc);
        check("sum_signed", longint'(out_sum), longint'(exp_signed));
        release_out();

        // Exact-width bound
        send({4'hF, 4'hF, 4'hF, 4'hF}, {4'hF, 4'hF, 4'hF, 4'hF}, 4'hF, 1'b0);
        wait_valid(cyc);
        check("sum_915", longint'(out_sum), 915);

        // Back-pressure: result must hold while inputs churn
        held = out_sum;
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            weights = weights ^ 16'h5A3C;
            inputs  = inputs + 16'h1111;
            step();
            check("hold_valid", longint'(out_valid), 1);
            check("hold_sum", longint'(out_sum), longint'(held));
        end
        in_valid = 1'b1;
        release_out();
        in_valid = 1'b0;
        check("no_accept_on_take", longint'(in_ready), 1);
        step();

        // Asynchronous reset mid-ACCUM
        send({4'd4, 4'd3, 4'd2, 4'd1}, {4'd8, 4'd7, 4'd6, 4'd5}, 4'd1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", longint'(out_valid), 0);
        check("arst_in_ready", longint'(in_ready), 1);
        check("arst_out_sum", longint'(out_sum), 0);
        step();
        rst_n = 1'b1;
        step();
        send({4'd4, 4'd3, 4'd2, 4'd1}, {4'd8, 4'd7, 4'd6, 4'd5}, 4'd0, 1'b0);
        wait_valid(cyc);
        check("post_reset_70", longint'(out_sum), 70);
        release_out();

        // Mixed vectors with out_ready tied high, checked by the model
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_idle();
            send(16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom));
        end
        wait_idle();
        out_ready = 1'b0;

        // Five inputs on two lanes: three beats, last slot padded
        w5 = {4'd2, 4'd1, 4'd1, 4'd1, 4'd1};
        x5 = {4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        bias = 4'd0; signed_mode = 1'b0; in_valid5 = 1'b1;
        step();
        in_valid5 = 1'b0;
        cyc = 0;
        while (!out_valid5 && cyc < 40) begin
            step();
            cyc++;
        end
        check("n5_latency", cyc, 3);
        check("n5_sum_20", longint'(out_sum5), 20);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("n5_in_ready", longint'(in_ready5), 1);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
